multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Parametrised multicycle control FSM for the KTC32 datapath: decodes the opcode and sequences fetch/decode/execute/writeback.
- Drives datapath mux selects, the ALU operation and write enables.
- Adds memory wait states (mem_req/mem_ready handshake), a wait-timeout watchdog, a JNE branch and illegal-opcode trapping.
- Every output is fully defined in every state; no X outputs.

Parameters:
- OPW, 6, opcode width. Must be 6 or more. Opcode bits [OPW-1:6] must be zero or the opcode is illegal.
- ACW, 3, alucontrol width. Must be 3 or more. Codes are zero-extended.
- WAIT_MAX, 15, maximum consecutive mem_ready-low cycles in one memory state before trapping. Must be 1 or more.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  OPW  opcode from instruction register
- mem_ready  in  1  memory completes the current access this cycle
- memtoreg  out  1  regfile write data select: 1 = memory data, 0 = ALU result
- iord  out  1  memory address select: 1 = ALU out, 0 = PC
- pcsrc  out  1  PC source: 1 = branch/jump target, 0 = ALU result
- alusrca  out  1  ALU A select: 1 = register, 0 = PC
- alusrcb  out  2  ALU B select: 00 = reg, 01 = const 4, 10 = zero, 11 = immediate
- alucontrol  out  ACW  ALU op: ADD 010, SUB 110, AND 000, OR 001, SLT 111
- irwrite, memwrite, pcwrite, regwrite  out  1 each  write enables
- branch  out  1  take branch if ALU zero
- branch_ne  out  1  take branch if not zero
- mem_req  out  1  memory access request
- illegal  out  1  sticky illegal-opcode flag
- timeout  out  1  sticky memory-timeout flag

Behaviour:
- Outputs are combinational from state, op and mem_ready. Defaults are all 0, alucontrol = ADD.
- Reset: state = FETCH, wait count = 0, illegal = 0, timeout = 0. Reset mid-instruction aborts it; no enable is asserted in the reset cycle.
- Opcodes (low 6 bits):
  - MOV 000000, ADD 100000, SUB 110000, AND 010000, OR 011000, SLT 001000
  - LW 000011, ADDI 100011, SW 000111
  - JMP 000001, JEQ 100001, JNE 110001
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = ADD.
  - irwrite and pcwrite assert only while mem_ready = 1. Advance to DECODE on that cycle, otherwise stay.
- DECODE: no enables. Next state:
  - LW/SW → MEMADR
  - ADDI → ADDIEX
  - R-type → EXEC
  - JEQ/JNE → BRANCH
  - JMP → JUMP
  - anything else, or nonzero upper bits → TRAP with illegal set
- MEMADR: alusrca = 1, alusrcb = 11, ADD. LW → MEMRD; SW → MEMWR.
- MEMRD: mem_req = 1, iord = 1. On mem_ready → MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1 → FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = mem_ready. On mem_ready → FETCH.
- EXEC: alusrca = 1. MOV uses alusrcb = 10 with ADD; others use alusrcb = 00 with their ALU op. → ALUWB.
- ADDIEX: alusrca = 1, alusrcb = 11, ADD → ALUWB.
- ALUWB: memtoreg = 0, regwrite = 1 → FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, SUB, pcsrc = 1. branch = 1 for JEQ; branch_ne = 1 for JNE. → FETCH.
- JUMP: pcsrc = 1, pcwrite = 1 → FETCH.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Increments each cycle with mem_req = 1 and mem_ready = 0; clears on state change.
  - When it reaches WAIT_MAX with mem_ready still low → TRAP with timeout set.
  - mem_ready = 1 on the WAIT_MAX-th cycle completes normally.
- TRAP: terminal until reset. All enables and mem_req = 0; the flags hold.
- Instruction latencies with zero-wait memory:
  - LW 5 cycles
  - SW, ADDI and R-type 4 cycles
  - JEQ, JNE and JMP 3 cycles
  - Each extra wait cycle adds 1.

Decomposition:
- Package ktc32_ctrl_pkg holds:
  - the statetype enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ADDIEX, ALUWB, BRANCH, JUMP, TRAP)
  - the 6-bit opcode constants
  - the ALU code constants
  - the alusrcb encodings
- One sub-module, ctrl_waitcnt: the wait counter and timeout comparator, width $clog2(WAIT_MAX+1).

Test Plan:
- ADD (op = 100000), mem_ready held at 1 → FETCH (irwrite = pcwrite = 1), DECODE, EXEC (alucontrol = 110 absent, 010 present, alusrcb = 00), ALUWB (regwrite = 1); 4 cycles total.
- LW with mem_ready low for 3 cycles in MEMRD → mem_req = 1 and iord = 1 for 4 cycles, then MEMWB with memtoreg = 1 and regwrite = 1; 8 cycles total.
- SW with WAIT_MAX = 4, mem_ready never high → TRAP after 4 wait cycles; timeout = 1, memwrite never 1, all enables 0 thereafter.
- JNE (110001) → BRANCH with branch_ne = 1, branch = 0, pcsrc = 1, alucontrol = 110. JEQ → branch = 1, branch_ne = 0.
- op = 111111, or OPW = 8 with op = 0100_0000 → DECODE then TRAP with illegal = 1. Assert reset → FETCH, illegal = 0.
- Reset asserted during MEMWR while mem_ready = 1 → memwrite = 0 immediately; after release, FETCH with mem_req = 1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the KTC32 multicycle control unit.
package ktc32_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ADDIEX, ALUWB, BRANCH, JUMP, TRAP
  } statetype;

  // Low six opcode bits
  localparam logic [5:0] OP_MOV  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b110000;
  localparam logic [5:0] OP_AND  = 6'b010000;
  localparam logic [5:0] OP_OR   = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b000111;
  localparam logic [5:0] OP_JMP  = 6'b000001;
  localparam logic [5:0] OP_JEQ  = 6'b100001;
  localparam logic [5:0] OP_JNE  = 6'b110001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_ZERO = 2'b10;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  // ALU operation for an R-type opcode; MOV falls through to ADD
  function automatic logic [2:0] rtype_alu(input logic [5:0] op6);
    case (op6)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the KTC32 datapath.
interface multicycle_ctrl_if #(
  parameter int OPW = 6,
  parameter int ACW = 3
);
  logic [OPW-1:0] op;
  logic           mem_ready;
  logic           memtoreg;
  logic           iord;
  logic           pcsrc;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [ACW-1:0] alucontrol;
  logic           irwrite;
  logic           memwrite;
  logic           pcwrite;
  logic           regwrite;
  logic           branch;
  logic           branch_ne;
  logic           mem_req;
  logic           illegal;
  logic           timeout;

  // Controller side
  modport master (
    input  op, mem_ready,
    output memtoreg, iord, pcsrc, alusrca, alusrcb, alucontrol,
           irwrite, memwrite, pcwrite, regwrite, branch, branch_ne,
           mem_req, illegal, timeout
  );

  // Datapath side
  modport slave (
    output op, mem_ready,
    input  memtoreg, iord, pcsrc, alusrca, alusrcb, alucontrol,
           irwrite, memwrite, pcwrite, regwrite, branch, branch_ne,
           mem_req, illegal, timeout
  );
endinterface

// File: rtl/multicycle_ctrl_waitcnt.sv
// Memory wait-state counter: counts consecutive stalled cycles inside one
// memory state and flags the cycle on which the limit is hit while stalled.
module ctrl_waitcnt #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_wait,
  output logic o_expire
);
  localparam int            CW  = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_cnt;

  // The WAIT_MAX-th stalled cycle is the one that expires
  assign o_expire = i_wait && (r_cnt == LIM);

  // Count stalled cycles; any state change restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_wait) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// KTC32 multicycle control FSM: sequences fetch/decode/execute/writeback,
// handles memory wait states with a watchdog, and traps illegal opcodes.
module multicycle_ctrl
  import ktc32_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int ACW      = 3,
  parameter int WAIT_MAX = 15
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);
  statetype       r_state, w_next;
  logic           r_illegal, r_timeout;
  logic           w_set_ill, w_set_to;
  logic [OPW-1:0] w_op;
  logic [5:0]     w_op6;
  logic           w_op_hi, w_wait, w_expire, w_clr;

  assign w_op    = bus.op;
  assign w_op6   = w_op[5:0];
  assign w_op_hi = (w_op >> 6) != '0;
  // Stall is derived from state directly so the counter never sees a comb loop
  assign w_wait  = (r_state == FETCH || r_state == MEMRD || r_state == MEMWR)
                   && !bus.mem_ready;
  assign w_clr   = (w_next != r_state);

  ctrl_waitcnt #(.WAIT_MAX(WAIT_MAX)) u_waitcnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_wait  (w_wait),
    .o_expire(w_expire)
  );

  assign bus.illegal = r_illegal;
  assign bus.timeout = r_timeout;

  // State register and sticky trap flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_to)  r_timeout <= 1'b1;
    end
  end

  // Next state and datapath controls; enables are forced low during reset
  always_comb begin
    w_next         = r_state;
    w_set_ill      = 1'b0;
    w_set_to       = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.iord       = 1'b0;
    bus.pcsrc      = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = SRCB_REG;
    bus.alucontrol = ACW'(ALU_ADD);
    bus.irwrite    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.mem_req    = 1'b0;
    case (r_state)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = SRCB_FOUR;
        if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          w_next      = DECODE;
        end else if (w_expire) begin
          w_next   = TRAP;
          w_set_to = 1'b1;
        end
      end
      DECODE: begin
        if (w_op_hi) begin
          w_next    = TRAP;
          w_set_ill = 1'b1;
        end else begin
          case (w_op6)
            OP_LW, OP_SW:                                 w_next = MEMADR;
            OP_ADDI:                                      w_next = ADDIEX;
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: w_next = EXEC;
            OP_JEQ, OP_JNE:                               w_next = BRANCH;
            OP_JMP:                                       w_next = JUMP;
            default: begin
              w_next    = TRAP;
              w_set_ill = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        w_next      = (w_op6 == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) w_next = MEMWB;
        else if (w_expire) begin
          w_next   = TRAP;
          w_set_to = 1'b1;
        end
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.memwrite = bus.mem_ready;
        if (bus.mem_ready) w_next = FETCH;
        else if (w_expire) begin
          w_next   = TRAP;
          w_set_to = 1'b1;
        end
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        if (w_op6 == OP_MOV) bus.alusrcb = SRCB_ZERO;
        else bus.alucontrol = ACW'(rtype_alu(w_op6));
        w_next = ALUWB;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        w_next      = ALUWB;
      end
      ALUWB: begin
        bus.regwrite = 1'b1;
        w_next       = FETCH;
      end
      BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ACW'(ALU_SUB);
        bus.pcsrc      = 1'b1;
        bus.branch     = (w_op6 == OP_JEQ);
        bus.branch_ne  = (w_op6 == OP_JNE);
        w_next         = FETCH;
      end
      JUMP: begin
        bus.pcsrc   = 1'b1;
        bus.pcwrite = 1'b1;
        w_next      = FETCH;
      end
      default: w_next = TRAP;
    endcase
    if (reset) begin
      bus.irwrite  = 1'b0;
      bus.memwrite = 1'b0;
      bus.pcwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.mem_req  = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a random instruction
// stream checked against per-instruction latency and enable-count rules.
module tb_multicycle_ctrl;
  localparam int OPW  = 8;
  localparam int ACW  = 3;
  localparam int WMAX = 4;

  localparam logic [5:0] T_MOV = 6'b000000, T_ADD = 6'b100000, T_SUB = 6'b110000;
  localparam logic [5:0] T_AND = 6'b010000, T_OR = 6'b011000, T_SLT = 6'b001000;
  localparam logic [5:0] T_LW = 6'b000011, T_ADDI = 6'b100011, T_SW = 6'b000111;
  localparam logic [5:0] T_JMP = 6'b000001, T_JEQ = 6'b100001, T_JNE = 6'b110001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_chk = 0;

  multicycle_ctrl_if #(.OPW(OPW), .ACW(ACW)) bus ();

  multicycle_ctrl #(.OPW(OPW), .ACW(ACW), .WAIT_MAX(WMAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int base_lat(input logic [5:0] o);
    case (o)
      T_LW:               return 5;
      T_JMP, T_JEQ, T_JNE: return 3;
      default:            return 4;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [5:0] o);
    case (o)
      T_SUB:   return 3'b110;
      T_AND:   return 3'b000;
      T_OR:    return 3'b001;
      T_SLT:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [1:0] exp_srcb(input logic [5:0] o);
    case (o)
      T_MOV:   return 2'b10;
      T_ADDI:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic step(input logic r);
    @(negedge clk);
    bus.mem_ready = r;
    #1;
  endtask

  // One instruction from FETCH with fw fetch stalls and mw data stalls
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    int L, ph, wc, cur;
    int n_ir = 0, n_pcw = 0, n_reg = 0, n_mtr = 0, n_mw = 0;
    int n_req = 0, n_iord = 0, n_pcs = 0, n_br = 0, n_bne = 0;
    logic is_lw, is_sw, is_mem, is_jmp, is_br, is_alu;
    is_lw  = (o == T_LW);
    is_sw  = (o == T_SW);
    is_mem = is_lw | is_sw;
    is_jmp = (o == T_JMP);
    is_br  = (o == T_JEQ) | (o == T_JNE);
    is_alu = !is_mem && !is_jmp && !is_br;
    L  = base_lat(o) + fw + (is_mem ? mw : 0);
    ph = 0;
    wc = 0;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      bus.op = {2'b00, o};
      cur = (ph == 0) ? fw : mw;
      if (bus.mem_req) bus.mem_ready = (wc == cur);
      else bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (c == 0) begin
        n_chk++;
        if ({bus.mem_req, bus.iord, bus.alusrca, bus.alusrcb, bus.alucontrol} !== {1'b1, 1'b0, 1'b0, 2'b01, 3'b010})
          $display("FAIL fetch_start op=%b: got %b want %b", o,
                   {bus.mem_req, bus.iord, bus.alusrca, bus.alusrcb, bus.alucontrol}, 8'b10001010);
        else n_pass++;
      end
      if (is_alu && c == L - 2) begin
        n_chk++;
        if ({bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regwrite} !== {1'b1, exp_srcb(o), exp_alu(o), 1'b0})
          $display("FAIL exec op=%b: got %b want %b", o,
                   {bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regwrite}, {1'b1, exp_srcb(o), exp_alu(o), 1'b0});
        else n_pass++;
      end
      if (is_br && c == L - 1) begin
        n_chk++;
        if ({bus.alusrca, bus.alusrcb, bus.alucontrol, bus.pcsrc, bus.branch, bus.branch_ne, bus.pcwrite}
            !== {1'b1, 2'b00, 3'b110, 1'b1, o == T_JEQ, o == T_JNE, 1'b0})
          $display("FAIL branch op=%b: got %b want %b", o,
                   {bus.alusrca, bus.alusrcb, bus.alucontrol, bus.pcsrc, bus.branch, bus.branch_ne, bus.pcwrite},
                   {1'b1, 2'b00, 3'b110, 1'b1, o == T_JEQ, o == T_JNE, 1'b0});
        else n_pass++;
      end
      n_ir += bus.irwrite;   n_pcw += bus.pcwrite;  n_reg += bus.regwrite;
      n_mtr += bus.memtoreg; n_mw += bus.memwrite;  n_req += bus.mem_req;
      n_iord += bus.iord;    n_pcs += bus.pcsrc;    n_br += bus.branch;
      n_bne += bus.branch_ne;
      if (bus.mem_req) begin
        if (bus.mem_ready) begin ph++; wc = 0; end
        else wc++;
      end
    end
    n_chk++;
    if ({8'(n_ir), 8'(n_pcw), 8'(n_reg), 8'(n_mtr), 8'(n_mw)}
        !== {8'd1, 8'(1 + is_jmp), 8'(is_lw | is_alu), 8'(is_lw), 8'(is_sw)})
      $display("FAIL write_counts op=%b fw=%0d mw=%0d: got %h want %h", o, fw, mw,
               {8'(n_ir), 8'(n_pcw), 8'(n_reg), 8'(n_mtr), 8'(n_mw)},
               {8'd1, 8'(1 + is_jmp), 8'(is_lw | is_alu), 8'(is_lw), 8'(is_sw)});
    else n_pass++;
    n_chk++;
    if ({8'(n_req), 8'(n_iord)} !== {8'(fw + 1 + (is_mem ? mw + 1 : 0)), 8'(is_mem ? mw + 1 : 0)})
      $display("FAIL mem_counts op=%b fw=%0d mw=%0d: got %h want %h", o, fw, mw,
               {8'(n_req), 8'(n_iord)}, {8'(fw + 1 + (is_mem ? mw + 1 : 0)), 8'(is_mem ? mw + 1 : 0)});
    else n_pass++;
    n_chk++;
    if ({8'(n_pcs), 8'(n_br), 8'(n_bne)} !== {8'(is_jmp | is_br), 8'(o == T_JEQ), 8'(o == T_JNE)})
      $display("FAIL pc_counts op=%b: got %h want %h", o, {8'(n_pcs), 8'(n_br), 8'(n_bne)},
               {8'(is_jmp | is_br), 8'(o == T_JEQ), 8'(o == T_JNE)});
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_chk++;
    if ({bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req, bus.illegal, bus.timeout} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req, bus.illegal, bus.timeout});
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.mem_req, bus.iord, bus.illegal, bus.timeout} !== 4'b1000)
      $display("FAIL reset_release: got %b want 1000", {bus.mem_req, bus.iord, bus.illegal, bus.timeout});
    else n_pass++;
  endtask

  task automatic test_add();
    run_instr(T_ADD, 0, 0);
    run_instr(T_ADDI, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(T_LW, 0, 3);
    run_instr(T_SW, 3, 3);
  endtask

  task automatic test_branches();
    run_instr(T_JNE, 0, 0);
    run_instr(T_JEQ, 0, 0);
    run_instr(T_JMP, 1, 0);
  endtask

  task automatic test_timeout();
    bus.op = {2'b00, T_SW};
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < WMAX; i++) begin
      step(1'b0);
      n_chk++;
      if ({bus.mem_req, bus.iord, bus.memwrite, bus.timeout} !== 4'b1100)
        $display("FAIL memwr_stall%0d: got %b want 1100", i, {bus.mem_req, bus.iord, bus.memwrite, bus.timeout});
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)));
      n_chk++;
      if ({bus.timeout, bus.illegal, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req} !== 7'b1000000)
        $display("FAIL timeout_trap%0d: got %b want 1000000", i,
                 {bus.timeout, bus.illegal, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req});
      else n_pass++;
    end
    test_reset();
  endtask

  task automatic test_illegal();
    logic [7:0] bad [2] = '{8'h3F, 8'h40};
    for (int k = 0; k < 2; k++) begin
      bus.op = bad[k];
      step(1'b1);
      n_chk++;
      if ({bus.irwrite, bus.pcwrite} !== 2'b11)
        $display("FAIL ill_fetch%0d: got %b want 11", k, {bus.irwrite, bus.pcwrite});
      else n_pass++;
      step(1'($urandom_range(0, 1)));
      n_chk++;
      if ({bus.illegal, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req} !== 6'b0)
        $display("FAIL ill_decode%0d: got %b want 000000", k,
                 {bus.illegal, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req});
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
        step(1'($urandom_range(0, 1)));
        n_chk++;
        if ({bus.illegal, bus.timeout, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req} !== 7'b1000000)
          $display("FAIL ill_trap%0d_%0d: got %b want 1000000", k, i,
                   {bus.illegal, bus.timeout, bus.irwrite, bus.memwrite, bus.pcwrite, bus.regwrite, bus.mem_req});
        else n_pass++;
      end
      test_reset();
      run_instr(T_ADD, 0, 0);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.op = {2'b00, T_SW};
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    n_chk++;
    if (bus.memwrite !== 1'b1) $display("FAIL memwr_ready: got %b want 1", bus.memwrite);
    else n_pass++;
    #1;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.memwrite, bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite} !== 5'b0)
      $display("FAIL reset_abort: got %b want 00000", {bus.memwrite, bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite});
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.mem_req, bus.iord, bus.alusrcb} !== 4'b1001)
      $display("FAIL abort_fetch: got %b want 1001", {bus.mem_req, bus.iord, bus.alusrcb});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] legal [12] = '{T_MOV, T_ADD, T_SUB, T_AND, T_OR, T_SLT,
                               T_LW, T_ADDI, T_SW, T_JMP, T_JEQ, T_JNE};
    for (int n = 0; n < 40; n++)
      run_instr(legal[$urandom_range(0, 11)], $urandom_range(0, WMAX - 1), $urandom_range(0, WMAX - 1));
    run_instr(T_ADD, 0, 0);
  endtask

  initial begin
    bus.op = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_timeout();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
